// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues word reads to a one-cycle-latency
// instruction memory and buffers {instruction, PC} pairs for the ID stage.
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter int               IM_AW    = 14,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [IM_AW-1:0]         im_addr,
    output logic                     im_req,
    input  logic [31:0]              im_rdata,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_instr,
    output logic [XLEN-1:0]          deq_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   occ_cnt;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] issue_pc;
    logic [CW:0]     pending;
    logic            deq_fire;
    logic            wr_en;
    logic            issue;
    logic            unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    always_comb begin
        target_pc = {redirect_pc[XLEN-1:2], 2'b00};
        issue_pc  = redirect ? target_pc : fetch_pc;
        deq_valid = !rst && (occ_cnt != '0) && !redirect;
        deq_fire  = deq_valid && deq_ready;
        // Entries that will be held once the outstanding read lands; a new
        // read may only go out if it is guaranteed a free slot.
        pending   = {1'b0, occ_cnt} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq_fire};
        issue     = !rst && (redirect || (pending < LIMIT));
        wr_en     = !rst && inflight && !redirect;
        im_req    = issue;
        im_addr   = rst ? RESET_PC[IM_AW+1:2] : issue_pc[IM_AW+1:2];
        count     = rst ? '0 : occ_cnt;
        deq_instr = instr_mem[rd_ptr];
        deq_pc    = pc_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            occ_cnt  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            // Flush: the only surviving fetch is the one issued at the target.
            fetch_pc <= target_pc + XLEN'(4);
            inflight <= 1'b1;
            occ_cnt  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                fetch_pc <= fetch_pc + XLEN'(4);
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire)
                rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !deq_fire)
                occ_cnt <= occ_cnt + CW'(1);
            else if (!wr_en && deq_fire)
                occ_cnt <= occ_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            inflight_pc <= issue_pc;
        if (wr_en) begin
            instr_mem[wr_ptr] <= im_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (occ_cnt == FULL) && !deq_fire));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus a stall/drain sequence.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int IM_AW = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             redirect = 1'b0;
    logic [XLEN-1:0]  redirect_pc = '0;
    logic             deq_ready = 1'b0;
    logic [31:0]      im_rdata = '0;
    logic [IM_AW-1:0] im_addr;
    logic             im_req;
    logic             deq_valid;
    logic [31:0]      deq_instr;
    logic [XLEN-1:0]  deq_pc;
    logic [2:0]       count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .IM_AW(IM_AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_req(im_req), .im_rdata(im_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
        .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [IM_AW-1:0] a);
        return {8'hA5, 10'h000, a};
    endfunction

    // Instruction memory with one-cycle read latency.
    always @(posedge clk) if (im_req) im_rdata <= instr_of(im_addr);

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [13:0] addr;
        logic        dv;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                                input logic ry, input logic q, input logic [13:0] a,
                                input logic v, input logic [31:0] p, input logic [2:0] c);
        vec_t t;
        t.rst = r; t.redir = rd; t.rpc = rp; t.rdy = ry;
        t.req = q; t.addr = a; t.dv = v; t.pc = p; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic ry);
        @(negedge clk);
        rst = r; redirect = rd; redirect_pc = rp; deq_ready = ry;
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        // rst, redir, rpc, rdy | req, addr, dv, pc, count
        tbl.push_back(mk(1,0,32'h0,1, 0,14'h0,   0,32'h0,0));
        tbl.push_back(mk(1,0,32'h0,1, 0,14'h0,   0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h0,   0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h1,   0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h2,   1,32'h0,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h3,   1,32'h4,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h4,   1,32'h8,1));
        tbl.push_back(mk(0,0,32'h0,0, 1,14'h5,   1,32'hC,1));
        tbl.push_back(mk(0,0,32'h0,0, 1,14'h6,   1,32'hC,2));
        tbl.push_back(mk(0,0,32'h0,0, 0,14'h7,   1,32'hC,3));
        tbl.push_back(mk(0,0,32'h0,0, 0,14'h7,   1,32'hC,4));
        tbl.push_back(mk(0,0,32'h0,0, 0,14'h7,   1,32'hC,4));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h7,   1,32'hC,4));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h8,   1,32'h10,3));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h9,   1,32'h14,3));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'hA,   1,32'h18,3));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'hB,   1,32'h1C,3));
        tbl.push_back(mk(0,1,32'h100,1, 1,14'h40, 0,32'h0,3));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h41,  0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h42,  1,32'h100,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h43,  1,32'h104,1));
        tbl.push_back(mk(0,1,32'h203,1, 1,14'h80, 0,32'h0,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h81,  0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h82,  1,32'h200,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h83,  1,32'h204,1));
        tbl.push_back(mk(0,1,32'hFFFFFFF8,1, 1,14'h3FFE, 0,32'h0,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h3FFF,1'b0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h0,   1,32'hFFFFFFF8,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h1,   1,32'hFFFFFFFC,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h2,   1,32'h0,1));
        tbl.push_back(mk(0,0,32'h0,0, 1,14'h3,   1,32'h4,1));
        tbl.push_back(mk(1,0,32'h0,1, 0,14'h0,   0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h0,   0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h1,   0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h2,   1,32'h0,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h3,   1,32'h4,1));
        tbl.push_back(mk(0,1,32'h300,1, 1,14'hC0, 0,32'h0,1));
        tbl.push_back(mk(0,1,32'h400,1, 1,14'h100,0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h101, 0,32'h0,0));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h102, 1,32'h400,1));
        tbl.push_back(mk(0,0,32'h0,1, 1,14'h103, 1,32'h404,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("row%0d im_req", i),    {31'b0, im_req},    {31'b0, tbl[i].req});
            chk($sformatf("row%0d im_addr", i),   {18'b0, im_addr},   {18'b0, tbl[i].addr});
            chk($sformatf("row%0d deq_valid", i), {31'b0, deq_valid}, {31'b0, tbl[i].dv});
            chk($sformatf("row%0d count", i),     {29'b0, count},     {29'b0, tbl[i].cnt});
            if (tbl[i].dv) begin
                chk($sformatf("row%0d deq_pc", i),    deq_pc,    tbl[i].pc);
                chk($sformatf("row%0d deq_instr", i), deq_instr, instr_of(tbl[i].pc[15:2]));
            end
        end

        // Stall until full: fetch must stop and the address must not run ahead.
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 32'h0, 0);
            checks++;
            if (count > 3'd4) begin
                errors++;
                $display("FAIL stall count bound: got %0d expected <= 4", count);
            end
        end
        chk("stall count full", {29'b0, count}, 32'd4);
        chk("stall im_req", {31'b0, im_req}, 32'd0);
        chk("stall im_addr", {18'b0, im_addr}, 32'h106);

        // Release: PCs drain in order, one per cycle, with no gap.
        exp_pc = 32'h408;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 32'h0, 1);
            chk($sformatf("drain%0d deq_valid", c), {31'b0, deq_valid}, 32'd1);
            chk($sformatf("drain%0d deq_pc", c), deq_pc, exp_pc);
            chk($sformatf("drain%0d deq_instr", c), deq_instr, instr_of(exp_pc[15:2]));
            exp_pc = exp_pc + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
